// File: rtl/grf_mp.sv
// grf_mp: multi-ported general register file with a per-register
// pending ("scoreboard") bit.
// - Two write ports. Port 1 wins when both write the same register.
// - NUM_RD combinational read ports.
// - Register 0 is hard-wired to zero and never becomes pending.
// - Optional macro GRF_BYPASS_EN forwards same-cycle write data, and the
//   matching pending-bit clear, to the read ports.
module grf_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_reg,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic                     busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage is plain flops because reset must clear every entry in one edge.
  logic [DATA_W-1:0] r_regs      [DEPTH];
  logic [DATA_W-1:0] w_regs_next [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_next;

  // Per-register next-state logic. Entry 0 is constant zero.
  // Write priority is port 1 over port 0. For the pending bit, an issue
  // takes precedence over a clear from either write port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign w_regs_next[gi] = '0;
      assign w_pend_next[gi] = 1'b0;
    end else begin : g_live
      localparam logic [ADDR_W-1:0] L_IDX = ADDR_W'(gi);
      logic w_hit0;
      logic w_hit1;
      logic w_iss;
      assign w_hit0 = we0 && (waddr0 == L_IDX);
      assign w_hit1 = we1 && (waddr1 == L_IDX);
      assign w_iss  = iss_valid && (iss_reg == L_IDX);
      assign w_regs_next[gi] = w_hit1 ? wdata1 :
                               w_hit0 ? wdata0 : r_regs[gi];
      assign w_pend_next[gi] = w_iss ? 1'b1 :
                               (w_hit0 || w_hit1) ? 1'b0 : r_pend[gi];
    end
  end

  // State update: reset discards all contents and all pending state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      r_regs <= w_regs_next;
      r_pend <= w_pend_next;
    end
  end

  // Read ports. Outputs are forced to zero while reset is high.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_rb;
    assign w_ra = raddr[gi*ADDR_W +: ADDR_W];
`ifdef GRF_BYPASS_EN
    logic w_hit0;
    logic w_hit1;
    logic w_iss;
    assign w_hit0 = we0 && (waddr0 == w_ra) && (w_ra != '0);
    assign w_hit1 = we1 && (waddr1 == w_ra) && (w_ra != '0);
    assign w_iss  = iss_valid && (iss_reg == w_ra);
    // Forward in-flight write data and the pending clear it will cause.
    always_comb begin
      w_rd = r_regs[w_ra];
      w_rb = r_pend[w_ra];
      if (w_hit1) begin
        w_rd = wdata1;
      end else if (w_hit0) begin
        w_rd = wdata0;
      end
      if ((w_hit0 || w_hit1) && !w_iss) begin
        w_rb = 1'b0;
      end
    end
`else
    assign w_rd = r_regs[w_ra];
    assign w_rb = r_pend[w_ra];
`endif
    assign rdata[gi*DATA_W +: DATA_W] = reset ? '0 : w_rd;
    assign rbusy[gi]                  = reset ? 1'b0 : w_rb;
  end

  // Only stored pending state feeds busy_any; a same-cycle issue is not included.
  assign busy_any = reset ? 1'b0 : (|r_pend);

endmodule

// File: tb/tb_grf_mp.sv
// Directed self-checking bench for grf_mp.
// The default build has no write-to-read bypass. When GRF_BYPASS_EN is
// defined, the expectations for same-cycle reads change to match the
// bypass build.
module tb_grf_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [DW-1:0]    wdata0, wdata1;
  logic             iss_valid;
  logic [AW-1:0]    iss_reg;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             busy_any;

  int n_tests = 0;
  int n_fail  = 0;

  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) begin
      $display("[TB] check %s obs=%h", tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_reg = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rdata[k*DW +: DW];
  endfunction

  initial begin
    // Reset cycle with a write and an issue present: neither may take effect.
    reset = 1'b1;
    idle();
    we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'hCAFE0001;
    iss_valid = 1'b1; iss_reg = 5'd2;
    set_ra(5'd2, 5'd2);
    #1;
    check("in_reset_rdata0", rd(0), 32'h0);
    check("in_reset_rbusy0", {31'b0, rbusy[0]}, 32'h0);
    check("in_reset_busy_any", {31'b0, busy_any}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("post_reset_r2", rd(0), 32'h0);
    check("post_reset_rbusy", {30'b0, rbusy}, 32'h0);
    check("post_reset_busy_any", {31'b0, busy_any}, 32'h0);

    // Write port 0 to r5, then read it back on the next cycle.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    tick();
    idle();
    set_ra(5'd5, 5'd0);
    #1;
    check("r5_data", rd(0), 32'hDEADBEEF);
    check("r5_rbusy", {31'b0, rbusy[0]}, 32'h0);

    // Both write ports target r7 in the same cycle: port 1 must win.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    tick();
    idle();
    set_ra(5'd0, 5'd7);
    #1;
    check("r7_port1_priority", rd(1), 32'h22222222);

    // Writes and issues to r0 are ignored.
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_reg = 5'd0;
    tick();
    idle();
    set_ra(5'd0, 5'd0);
    #1;
    check("r0_reads_zero", rd(0), 32'h0);
    check("r0_rbusy", {31'b0, rbusy[0]}, 32'h0);
    check("r0_issue_busy_any", {31'b0, busy_any}, 32'h0);

    // Issue r3. busy_any must not reflect the issue before the edge.
    iss_valid = 1'b1; iss_reg = 5'd3;
    set_ra(5'd3, 5'd0);
    #1;
    check("r3_issue_same_cycle_busy_any", {31'b0, busy_any}, 32'h0);
    tick();
    idle();
    #1;
    check("r3_pending", {31'b0, rbusy[0]}, 32'h1);
    check("r3_busy_any", {31'b0, busy_any}, 32'h1);

    // Write r3 = 5. Before the edge, only the bypass build forwards it.
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h5;
    #1;
`ifdef GRF_BYPASS_EN
    check("r3_write_same_cycle_rbusy", {31'b0, rbusy[0]}, 32'h0);
    check("r3_write_same_cycle_data", rd(0), 32'h5);
`else
    check("r3_write_same_cycle_rbusy", {31'b0, rbusy[0]}, 32'h1);
    check("r3_write_same_cycle_data", rd(0), 32'h0);
`endif
    tick();
    idle();
    #1;
    check("r3_cleared_rbusy", {31'b0, rbusy[0]}, 32'h0);
    check("r3_cleared_busy_any", {31'b0, busy_any}, 32'h0);
    check("r3_data", rd(0), 32'h5);

    // Issue and write r3 in the same cycle: the pending bit stays set.
    iss_valid = 1'b1; iss_reg = 5'd3;
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h6;
    tick();
    idle();
    #1;
    check("r3_issue_wins_rbusy", {31'b0, rbusy[0]}, 32'h1);
    check("r3_issue_wins_data", rd(0), 32'h6);
    check("r3_issue_wins_busy_any", {31'b0, busy_any}, 32'h1);
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h7;
    tick();
    idle();
    #1;
    check("r3_final_clear", {31'b0, busy_any}, 32'h0);

    // A write to a non-pending register leaves its pending bit at 0.
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h0A0A0A0A;
    we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h0B0B0B0B;
    tick();
    idle();
    set_ra(5'd10, 5'd11);
    #1;
    check("r10_data", rd(0), 32'h0A0A0A0A);
    check("r11_data", rd(1), 32'h0B0B0B0B);
    check("r10_r11_rbusy", {30'b0, rbusy}, 32'h0);

    // r6 is pending, then written while port 1 reads r6 in the same cycle.
    iss_valid = 1'b1; iss_reg = 5'd6;
    tick();
    idle();
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h1234;
    set_ra(5'd7, 5'd6);
    #1;
`ifdef GRF_BYPASS_EN
    check("r6_bypass_data", rd(1), 32'h1234);
    check("r6_bypass_rbusy", {31'b0, rbusy[1]}, 32'h0);
`else
    check("r6_same_cycle_data", rd(1), 32'h0);
    check("r6_same_cycle_rbusy", {31'b0, rbusy[1]}, 32'h1);
`endif
    tick();
    idle();
    #1;
    check("r6_after_data", rd(1), 32'h1234);
    check("r6_after_rbusy", {31'b0, rbusy[1]}, 32'h0);

    // Both ports write r7 while it is being read; the bypass build must
    // forward port 1's data.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h33333333;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h44444444;
    set_ra(5'd7, 5'd0);
    #1;
`ifdef GRF_BYPASS_EN
    check("r7_same_cycle_read", rd(0), 32'h44444444);
`else
    check("r7_same_cycle_read", rd(0), 32'h22222222);
`endif
    tick();
    idle();
    #1;
    check("r7_after_dual_write", rd(0), 32'h44444444);

    // Build up pending and written state, then reset in the middle of it.
    iss_valid = 1'b1; iss_reg = 5'd4;
    tick();
    iss_reg = 5'd9;
    tick();
    idle();
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hA5;
    tick();
    idle();
    set_ra(5'd12, 5'd9);
    #1;
    check("r12_data", rd(0), 32'hA5);
    check("r9_pending", {31'b0, rbusy[1]}, 32'h1);
    check("pre_reset_busy_any", {31'b0, busy_any}, 32'h1);
    reset = 1'b1;
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'hBB;
    iss_valid = 1'b1; iss_reg = 5'd12;
    #1;
    check("mid_reset_rdata0", rd(0), 32'h0);
    check("mid_reset_rbusy", {30'b0, rbusy}, 32'h0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("after_reset_r12", rd(0), 32'h0);
    check("after_reset_r9_rbusy", {31'b0, rbusy[1]}, 32'h0);
    check("after_reset_busy_any", {31'b0, busy_any}, 32'h0);
    set_ra(5'd5, 5'd4);
    #1;
    check("after_reset_r5", rd(0), 32'h0);
    check("after_reset_r4_rbusy", {31'b0, rbusy[1]}, 32'h0);
    tick();
    set_ra(5'd12, 5'd12);
    #1;
    check("after_reset_r12_stays_clear", {31'b0, busy_any}, 32'h0);
    check("after_reset_r12_rbusy", {30'b0, rbusy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/grf_mp.md
GRF_MP -- requirements
Module: grf_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of read ports, 1..4.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 we0 / we1  in  1 each  write enables, ports 0 and 1.
REQ-007 waddr0 / waddr1  in  ADDR_W each  write addresses.
REQ-008 wdata0 / wdata1  in  DATA_W each  write data.
REQ-009 iss_valid  in  1  issue strobe: marks iss_reg as pending a future write.
REQ-010 iss_reg  in  ADDR_W  destination register being issued.
REQ-011 raddr  in  NUM_RD*ADDR_W  flattened read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 rdata  out  NUM_RD*DATA_W  flattened read data, same packing.
REQ-013 rbusy  out  NUM_RD  per-port flag: addressed register has an outstanding pending write.
REQ-014 busy_any  out  1  OR of all pending bits.

Function
REQ-015 Register 0 reads as 0 and is never written; its pending bit stays 0.
REQ-016 Reads are combinational from raddr; rdata and rbusy need no clock.
REQ-017 Writes commit on the rising edge of clk when weN=1 and waddrN!=0.
REQ-018 If we0 and we1 target the same non-zero address in one cycle, wdata1 is stored; port 1 has priority.
REQ-019 Pending bit of register r sets on the edge where iss_valid=1 and iss_reg=r (r!=0).
REQ-020 Pending bit of register r clears on the edge where either write port writes r.
REQ-021 Set and clear of the same register in one cycle leave the bit set; issue wins.
REQ-022 Writes are accepted whether or not the target is pending; a write to a non-pending register leaves its bit 0.
REQ-023 rbusy[k] is the stored pending bit of raddr port k, and is 0 for address 0.
REQ-024 busy_any is registered-state derived; it never reflects same-cycle issue.
REQ-025 Address arithmetic is unsigned ADDR_W bits; no out-of-range addresses exist.

Reset
REQ-026 With reset=1 at a rising edge, every register and every pending bit becomes 0.
REQ-027 Reset overrides same-cycle writes and issues; none take effect.
REQ-028 During and after reset, rdata = 0, rbusy = 0 and busy_any = 0.
REQ-029 Reset asserted mid-sequence, e.g. with outstanding pending bits, discards all pending state; no later write is required to clear it.

Configuration
REQ-030 Macro GRF_BYPASS_EN compiles in write-to-read forwarding.
REQ-031 With GRF_BYPASS_EN defined, a read port addressing a non-zero register being written this cycle returns that write data, port 1 if both hit.
REQ-032 With GRF_BYPASS_EN defined, the same port's rbusy reads 0 when the write would clear it and no same-cycle issue targets it.
REQ-033 Without GRF_BYPASS_EN, reads return stored contents only; new data is visible from the cycle after the write edge.
REQ-034 Reset behaviour and register 0 rules are identical in both builds.

Verification
REQ-035 Reset, then write 0xDEADBEEF via port 0 to r5; next cycle raddr port 0 = 5 -> rdata 0xDEADBEEF, rbusy 0.
REQ-036 Same cycle we0 and we1 to r7 with 0x11111111 / 0x22222222 -> r7 reads 0x22222222.
REQ-037 Write 0xFFFFFFFF to r0 -> r0 reads 0. Issue r0 -> busy_any stays 0.
REQ-038 Issue r3, one cycle later rbusy for r3 = 1 and busy_any = 1. Write r3 = 0x5 -> next cycle rbusy 0, busy_any 0. Then issue r3 while writing r3 -> bit stays 1.
REQ-039 Issue r4 and r9, write r12 = 0xA5, then assert reset one cycle -> all rdata 0, rbusy 0, busy_any 0. r12 is not written in the reset cycle.
REQ-040 GRF_BYPASS_EN build: r6 pending, write r6 = 0x1234 with raddr = 6 in the same cycle -> rdata 0x1234, rbusy 0. Non-bypass build: same-cycle read shows old value and rbusy 1.
